// File: rtl/adc_conversion_sequencer.sv
// adc_conversion_sequencer: paces a CNV/BUSY SAR ADC.
// After an idle gap of `divider` clocks it raises cnv. It holds cnv until the ADC busy pulse
// has been seen and has ended, then strobes trigger for the readout logic. It free-runs until
// halted by `last` or cfg[0]. A busy that never arrives is bounded by BUSY_TIMEOUT.
module adc_conversion_sequencer #(
  parameter int unsigned CNV_MIN_CYCLES = 2,
  parameter int unsigned BUSY_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] divider,
  input  logic [31:0] cfg,
  output logic        trigger,
  output logic        cnv,
  input  logic        busy,
  input  logic        last
);

  // Last cnt value of the minimum cnv width and of the busy watchdog.
  localparam logic [31:0] MIN_LAST     = 32'(CNV_MIN_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CONV = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        cnv_q, cnv_d;
  logic        busy_seen_q, busy_seen_d;
  logic        halted_q, halted_d;

  logic        cfg_halt;
  logic        cfg_rearm;
  logic        stop;
  logic        eoc;
  logic        unused_cfg_bits;

  assign cfg_halt        = cfg[0];
  assign cfg_rearm       = cfg[1];
  assign unused_cfg_bits = ^cfg[31:2];
  assign cnv             = cnv_q;

  // State, counter and flags; cnv drops the moment resetn asserts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cnv_q       <= 1'b0;
      busy_seen_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cnv_q       <= cnv_d;
      busy_seen_q <= busy_seen_d;
      halted_q    <= halted_d;
    end
  end

  // Next-state logic, halt bookkeeping and the combinational end-of-conversion strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_seen_d = busy_seen_q;

    // Re-arm wins over a same-cycle last; the sticky halt is visible this cycle.
    halted_d = halted_q;
    if (cfg_rearm) begin
      halted_d = 1'b0;
    end else if (last) begin
      halted_d = 1'b1;
    end
    stop = halted_d | cfg_halt;

    eoc     = busy_seen_q & ~busy & (cnt_q >= MIN_LAST);
    trigger = (state_q == CONV) & eoc;

    case (state_q)
      IDLE: begin
        cnt_d       = '0;
        busy_seen_d = 1'b0;
        if ((divider != 32'd0) && !stop) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (stop || (divider == 32'd0)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= divider - 32'd1) begin
          // >= so that lowering divider mid-count fires straight away.
          state_d = CONV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      CONV: begin
        busy_seen_d = busy_seen_q | busy;
        cnt_d       = cnt_q + 32'd1;
        // Both normal completion and the busy watchdog leave through here, so cnv can
        // only rise again after a fresh WAIT gap, never while busy is still high.
        if (eoc || (cnt_q >= TIMEOUT_LAST)) begin
          busy_seen_d = 1'b0;
          cnt_d       = '0;
          state_d     = stop ? IDLE : WAIT;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        busy_seen_d = 1'b0;
      end
    endcase

    cnv_d = (state_d == CONV);
  end

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// Bench for adc_conversion_sequencer.
// The expected timing comes from schedule arithmetic. Conversion k's cnv rises at a cycle
// computed from the previous conversion's end plus the gap. The ADC model raises busy d cycles
// later for L cycles. trigger is expected in the first cycle that busy is low again, and cnv
// falls on the following edge.
`timescale 1ns/1ps
module tb_adc_conversion_sequencer;

  localparam int BUSY_TIMEOUT = 1024;

  logic        clk;
  logic        resetn;
  logic [31:0] divider;
  logic [31:0] cfg;
  logic        trigger;
  logic        cnv;
  logic        busy;
  logic        last;

  int cyc;
  int bs, be;
  int last_at;
  int zero_div_at;
  int total, passed, failed;

  adc_conversion_sequencer #(
    .CNV_MIN_CYCLES(2),
    .BUSY_TIMEOUT  (BUSY_TIMEOUT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .divider(divider),
    .cfg    (cfg),
    .trigger(trigger),
    .cnv    (cnv),
    .busy   (busy),
    .last   (last)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: the ADC model and scheduled pulses are driven 1ns after the edge.
  // Outputs are sampled 2ns after the edge.
  task automatic next_cycle();
    @(posedge clk);
    cyc++;
    #1;
    busy = (cyc >= bs) && (cyc < be);
    last = (cyc == last_at);
    if (cyc == zero_div_at) divider = '0;
    #1;
  endtask

  // Expect cnv to rise at `rise`. len>0: busy runs for cycles rise+d .. rise+d+len-1 and
  // trigger comes at f = rise+d+len. len==0: busy never comes, the watchdog ends the
  // conversion after BUSY_TIMEOUT cycles, and no trigger is issued.
  task automatic run_conv(input int rise, input int d, input int len, output int f);
    if (len > 0) begin
      bs = rise + d;
      be = bs + len;
      f  = be;
    end else begin
      bs = 0;
      be = 0;
      f  = rise + BUSY_TIMEOUT - 1;
    end
    while (cyc < rise) begin
      next_cycle();
      if (cyc < rise) begin
        chk("gap_cnv", cnv, 0);
        chk("gap_trigger", trigger, 0);
      end
    end
    chk("cnv_rise", cnv, 1);
    chk("busy_at_rise", busy, 0);
    chk("trigger_at_rise", trigger, 0);
    while (cyc < f) begin
      next_cycle();
      chk("conv_cnv", cnv, 1);
      chk("conv_trigger", trigger, 32'((len > 0) && (cyc == f)));
    end
  endtask

  task automatic quiet(input int n, input string tag);
    repeat (n) begin
      next_cycle();
      chk(tag, cnv, 0);
      chk({tag, "_trig"}, trigger, 0);
    end
  endtask

  initial begin
    int f, c, rise, d, len;
    total = 0; passed = 0; failed = 0;
    cyc = 0; bs = 0; be = 0; last_at = -1; zero_div_at = -1;
    resetn = 1'b0; divider = '0; cfg = '0; busy = 1'b0; last = 1'b0;

    // Reset state
    repeat (3) begin
      next_cycle();
      chk("reset_cnv", cnv, 0);
      chk("reset_trigger", trigger, 0);
    end
    resetn = 1'b1;

    // divider=0 keeps the sequencer idle
    quiet(20, "disabled_cnv");

    // First conversion, divider=50, busy ~282ns -> 15 cycles at 50 MHz
    divider = 32'd50;
    run_conv(cyc + 51, 1, 15, f);

    // Ten free-running conversions with randomised busy timing and later random gaps
    for (int i = 0; i < 10; i++) begin
      if (i >= 3) divider = 32'($urandom_range(1, 12));
      d   = int'($urandom_range(1, 3));
      len = int'($urandom_range(1, 20));
      run_conv(f + 1 + int'(divider), d, len, f);
    end

    // last pulsed one cycle after trigger: no more conversions
    divider = 32'd50;
    last_at = f + 1;
    quiet(100, "halted_cnv");

    // Re-arm via cfg[1]
    cfg = 32'd2;
    c = cyc;
    next_cycle();
    chk("rearm_cnv", cnv, 0);
    cfg = '0;
    run_conv(c + 51, 1, 15, f);

    // last during CONV: conversion still completes with trigger, then halt
    divider = 32'd6;
    rise = f + 7;
    last_at = rise + 2;
    run_conv(rise, 1, 5, f);
    quiet(30, "halt_in_conv_cnv");
    cfg = 32'd2;
    c = cyc;
    next_cycle();
    chk("rearm2_cnv", cnv, 0);
    cfg = '0;
    run_conv(c + 7, 2, 4, f);

    // cfg[0] held during WAIT stops sequencing only while held
    divider = 32'd10;
    quiet(3, "cfg0_pre_cnv");
    cfg = 32'd1;
    quiet(20, "cfg0_hold_cnv");
    cfg = '0;
    run_conv(cyc + 11, 1, 6, f);

    // divider drops to 0 mid-conversion: it completes, then the sequencer idles
    divider = 32'd5;
    rise = f + 6;
    zero_div_at = rise + 1;
    run_conv(rise, 2, 6, f);
    quiet(12, "div0_cnv");
    divider = 32'd7;
    run_conv(cyc + 8, 1, 3, f);

    // Busy never asserted: watchdog drops cnv after BUSY_TIMEOUT cycles, no trigger
    divider = 32'd5;
    run_conv(f + 6, 0, 0, f);
    run_conv(f + 6, 1, 3, f);

    // Asynchronous reset in the middle of a conversion
    divider = 32'd4;
    rise = f + 5;
    bs = rise + 1;
    be = rise + 30;
    while (cyc < rise) begin
      next_cycle();
      if (cyc < rise) chk("pre_reset_gap_cnv", cnv, 0);
    end
    chk("pre_reset_cnv", cnv, 1);
    next_cycle();
    next_cycle();
    chk("pre_reset_hold_cnv", cnv, 1);
    #5;
    resetn = 1'b0;
    #1;
    chk("reset_async_cnv", cnv, 0);
    chk("reset_async_trigger", trigger, 0);
    divider = '0;
    bs = 0;
    be = 0;
    quiet(2, "reset_hold_cnv");
    resetn = 1'b1;
    quiet(10, "post_reset_cnv");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
